// File: rtl/alu_seq.sv
// Handshaked, registered ALU with full flag set and an iterative shift-add multiplier.
// Single-cycle ops complete at the accept edge; MUL iterates one partial product per cycle.
module alu_seq #(
   parameter int DATA_WIDTH  = 16,
   parameter int SHAMT_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [3:0]            alu_control,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] alu_result,
   output logic                  zero_flag,
   output logic                  carry_flag,
   output logic                  neg_flag,
   output logic                  ovf_flag,
   output logic                  illegal_op
);

   localparam int CNT_W = SHAMT_WIDTH + 1;
   localparam logic [CNT_W-1:0] MUL_END = CNT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_SLT = 4'd5,
      OP_XOR = 4'd6,
      OP_SLL = 4'd7,
      OP_SRL = 4'd8,
      OP_SRA = 4'd9,
      OP_MUL = 4'd10
   } op_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [DATA_WIDTH-1:0]  acc;
   logic [DATA_WIDTH-1:0]  mcand;
   logic [DATA_WIDTH-1:0]  mplier;

   logic                   accept;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [DATA_WIDTH:0]    sum_w;
   logic [DATA_WIDTH:0]    diff_w;
   logic [DATA_WIDTH-1:0]  res_c;
   logic                   carry_c;
   logic                   ovf_c;
   logic                   ill_c;

   // DONE can retire and accept on the same edge, giving zero-bubble back-to-back ops.
   assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign shamt    = b[SHAMT_WIDTH-1:0];
   assign sum_w    = {1'b0, a} + {1'b0, b};
   assign diff_w   = {1'b0, a} - {1'b0, b};

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      ill_c   = 1'b0;
      case (alu_control)
         OP_NOP: res_c = '0;
         OP_ADD: begin
            res_c   = sum_w[DATA_WIDTH-1:0];
            carry_c = sum_w[DATA_WIDTH];
            ovf_c   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                      (sum_w[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         OP_SUB: begin
            res_c   = diff_w[DATA_WIDTH-1:0];
            carry_c = diff_w[DATA_WIDTH];
            ovf_c   = (a[DATA_WIDTH-1] == ~b[DATA_WIDTH-1]) &&
                      (diff_w[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         OP_AND: res_c = a & b;
         OP_OR:  res_c = a | b;
         OP_XOR: res_c = a ^ b;
         OP_SLT: res_c = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: res_c = a << shamt;
         OP_SRL: res_c = a >> shamt;
         OP_SRA: res_c = $unsigned($signed(a) >>> shamt);
         OP_MUL: res_c = '0;
         default: begin
            res_c = '0;
            ill_c = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         out_valid  <= 1'b0;
         alu_result <= '0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
         neg_flag   <= 1'b0;
         ovf_flag   <= 1'b0;
         illegal_op <= 1'b0;
      end else if (accept) begin
         if (alu_control == OP_MUL) begin
            state     <= S_MUL;
            out_valid <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= a;
            mplier    <= b;
         end else begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            alu_result <= res_c;
            zero_flag  <= (res_c == '0);
            carry_flag <= carry_c;
            neg_flag   <= res_c[DATA_WIDTH-1];
            ovf_flag   <= ovf_c;
            illegal_op <= ill_c;
         end
      end else begin
         case (state)
            S_MUL: begin
               // Iterations run at cnt 0..DATA_WIDTH-1; the extra cycle at MUL_END publishes acc.
               if (cnt == MUL_END) begin
                  state      <= S_DONE;
                  out_valid  <= 1'b1;
                  alu_result <= acc;
                  zero_flag  <= (acc == '0);
                  carry_flag <= 1'b0;
                  neg_flag   <= acc[DATA_WIDTH-1];
                  ovf_flag   <= 1'b0;
                  illegal_op <= 1'b0;
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at DATA_WIDTH=8, SHAMT_WIDTH=3.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] alu_control;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] alu_result;
   logic       zero_flag;
   logic       carry_flag;
   logic       neg_flag;
   logic       ovf_flag;
   logic       illegal_op;

   int checks = 0;
   int errors = 0;

   alu_seq #(.DATA_WIDTH(8), .SHAMT_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
      .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
      .carry_flag(carry_flag), .neg_flag(neg_flag), .ovf_flag(ovf_flag),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
      in_valid    = 1'b1;
      alu_control = op;
      a           = va;
      b           = vb;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; alu_control = '0;
      step(); step();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || alu_result !== 8'h00 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: out_valid=%b result=%h in_ready=%b, want 0 00 1", out_valid, alu_result, in_ready);
      end
      checks++;
      if ({zero_flag, carry_flag, neg_flag, ovf_flag, illegal_op} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: zcnvi=%b want 00000", {zero_flag, carry_flag, neg_flag, ovf_flag, illegal_op});
      end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      drive(4'h1, 8'hFF, 8'h01);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 8'h00 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL add_result: ov=%b res=%h rdy=%b want 1 00 1", out_valid, alu_result, in_ready);
      end
      checks++;
      if ({zero_flag, carry_flag, neg_flag, ovf_flag} !== 4'b1100) begin
         errors++;
         $display("FAIL add_flags: zcnv=%b want 1100", {zero_flag, carry_flag, neg_flag, ovf_flag});
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_retire: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      drive(4'h2, 8'h80, 8'h01);
      step();
      checks++;
      if (alu_result !== 8'h7F || {zero_flag, carry_flag, neg_flag, ovf_flag} !== 4'b0001) begin
         errors++;
         $display("FAIL sub: res=%h zcnv=%b want 7f 0001", alu_result, {zero_flag, carry_flag, neg_flag, ovf_flag});
      end
      drive(4'h5, 8'hFE, 8'h01);
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 8'h01 || carry_flag !== 1'b0 || ovf_flag !== 1'b0) begin
         errors++;
         $display("FAIL slt: ov=%b res=%h c=%b v=%b want 1 01 0 0", out_valid, alu_result, carry_flag, ovf_flag);
      end
      drive(4'h9, 8'h90, 8'h02);
      step();
      checks++;
      if (alu_result !== 8'hE4 || neg_flag !== 1'b1 || zero_flag !== 1'b0) begin
         errors++;
         $display("FAIL sra: res=%h n=%b z=%b want e4 1 0", alu_result, neg_flag, zero_flag);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_logic_shift();
      logic [3:0] ops [6] = '{4'h3, 4'h4, 4'h7, 4'h8, 4'h0, 4'h5};
      logic [7:0] va  [6] = '{8'hCA, 8'hCA, 8'h81, 8'h81, 8'h12, 8'h01};
      logic [7:0] vb  [6] = '{8'h0F, 8'h05, 8'h0B, 8'h02, 8'h34, 8'hFE};
      logic [7:0] exp [6] = '{8'h0A, 8'hCF, 8'h08, 8'h20, 8'h00, 8'h00};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(ops[i], va[i], vb[i]);
         step();
         checks++;
         if (out_valid !== 1'b1 || alu_result !== exp[i] || zero_flag !== (exp[i] == 8'h00) ||
             carry_flag !== 1'b0 || ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL logic_shift[%0d]: ov=%b res=%h z=%b c=%b v=%b want 1 %h %b 0 0",
                     i, out_valid, alu_result, zero_flag, carry_flag, ovf_flag, exp[i], exp[i] == 8'h00);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_mul();
      int n;
      out_ready = 1'b0;
      drive(4'hA, 8'h0D, 8'h0B);
      step();
      drive(4'h1, 8'h11, 8'h22);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         if (out_valid === 1'b1) break;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_in_ready: cycle %0d in_ready=%b want 0", k - 1, in_ready);
         end
         step();
         n = k;
      end
      checks++;
      if (n != 9 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mul_latency: got %0d cycles (out_valid=%b) want 9", n, out_valid);
      end
      checks++;
      if (alu_result !== 8'h8F || {zero_flag, carry_flag, neg_flag, ovf_flag, illegal_op} !== 5'b00100) begin
         errors++;
         $display("FAIL mul_result: res=%h zcnvi=%b want 8f 00100", alu_result,
                  {zero_flag, carry_flag, neg_flag, ovf_flag, illegal_op});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || alu_result !== 8'h8F) begin
         errors++;
         $display("FAIL mul_ignored_input: ov=%b res=%h want 0 8f", out_valid, alu_result);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(4'h1, 8'h03, 8'h04);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b1 || alu_result !== 8'h07 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure[%0d]: ov=%b res=%h rdy=%b want 1 07 0", k, out_valid, alu_result, in_ready);
         end
         step();
      end
      drive(4'h6, 8'hF0, 8'h0F);
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handoff_ready: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 8'hFF || neg_flag !== 1'b1) begin
         errors++;
         $display("FAIL handoff_xor: ov=%b res=%h n=%b want 1 ff 1", out_valid, alu_result, neg_flag);
      end
      step();
   endtask

   task automatic test_reset_mid_mul();
      out_ready = 1'b1;
      drive(4'hA, 8'h0D, 8'h0B);
      step();
      in_valid = 1'b0;
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || alu_result !== 8'h00 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_mul_reset: ov=%b res=%h rdy=%b want 0 00 1", out_valid, alu_result, in_ready);
      end
      drive(4'h1, 8'h01, 8'h01);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 8'h02) begin
         errors++;
         $display("FAIL post_reset_add: ov=%b res=%h want 1 02", out_valid, alu_result);
      end
      step();
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_mul[%0d]: out_valid=%b want 0", k, out_valid);
         end
         step();
      end
   endtask

   task automatic test_illegal();
      logic [3:0] ops [3] = '{4'hC, 4'hB, 4'hF};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(ops[i], 8'h05, 8'h03);
         step();
         checks++;
         if (out_valid !== 1'b1 || alu_result !== 8'h00 || zero_flag !== 1'b1 || illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL illegal[%h]: ov=%b res=%h z=%b ill=%b want 1 00 1 1",
                     ops[i], out_valid, alu_result, zero_flag, illegal_op);
         end
      end
      drive(4'h1, 8'h05, 8'h03);
      step();
      in_valid = 1'b0;
      checks++;
      if (illegal_op !== 1'b0 || alu_result !== 8'h08) begin
         errors++;
         $display("FAIL illegal_clear: ill=%b res=%h want 0 08", illegal_op, alu_result);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_logic_shift();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_illegal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
